// File: rtl/ntt_pkg.sv
// +----------------------------------------------------------------------------+
// | ntt_pkg: shared types and geometry helpers for the NTT stream adapter.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package ntt_pkg;

  localparam int DEFAULT_COEFF_WIDTH = 30;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_START   = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DRAIN   = 2'd3
  } ntt_adapter_state_t;

  function automatic int calc_line_aw(input int log_n, input int log_core_count);
    return log_n - 2 - log_core_count;
  endfunction

  function automatic int calc_lines(input int log_n, input int log_core_count);
    return 1 << calc_line_aw(log_n, log_core_count);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ntt_result_buffer.sv
// +----------------------------------------------------------------------------+
// | ntt_result_buffer: line-wide write, single-coefficient registered read.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ntt_result_buffer #(
  parameter int LINES           = 2,
  parameter int LINE_AW         = 1,
  parameter int COEFFS_PER_LINE = 8,
  parameter int SEL_AW          = 3,
  parameter int COEFF_WIDTH     = 30
) (
  input  logic                                   clk,
  input  logic                                   wr_en,
  input  logic [LINE_AW-1:0]                     wr_line,
  input  logic [COEFFS_PER_LINE*COEFF_WIDTH-1:0] wr_data,
  input  logic                                   rd_en,
  input  logic [LINE_AW-1:0]                     rd_line,
  input  logic [SEL_AW-1:0]                      rd_sel,
  output logic [COEFF_WIDTH-1:0]                 rd_data
);

  logic [COEFFS_PER_LINE*COEFF_WIDTH-1:0] mem [LINES];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_line] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_line][rd_sel*COEFF_WIDTH +: COEFF_WIDTH];
    end
  end

endmodule

`default_nettype wire

// File: rtl/ntt_stream_adapter.sv
// +----------------------------------------------------------------------------+
// | ntt_stream_adapter: valid/ready coefficient streams around ntt_processor.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ntt_stream_adapter
  import ntt_pkg::*;
#(
  parameter int LOG_N          = 12,
  parameter int COEFF_WIDTH    = DEFAULT_COEFF_WIDTH,
  parameter int LOG_CORE_COUNT = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      s_valid,
  output logic                                      s_ready,
  input  logic [COEFF_WIDTH-1:0]                    s_data,
  output logic                                      m_valid,
  input  logic                                      m_ready,
  output logic [COEFF_WIDTH-1:0]                    m_data,
  output logic                                      m_last,
  output logic                                      proc_write_enable,
  output logic [LOG_N-2:0]                          proc_address_in,
  output logic [2*COEFF_WIDTH-1:0]                  proc_data_in,
  output logic                                      proc_start,
  input  logic                                      proc_output_active,
  input  logic [(4<<LOG_CORE_COUNT)*COEFF_WIDTH-1:0] proc_out,
  input  logic [8:0]                                proc_address_out,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      err
);

  localparam int CPL     = 4 << LOG_CORE_COUNT;
  localparam int SEL_AW  = LOG_CORE_COUNT + 2;
  localparam int LINE_AW = calc_line_aw(LOG_N, LOG_CORE_COUNT);
  localparam int LINES   = calc_lines(LOG_N, LOG_CORE_COUNT);
  localparam logic [LINE_AW:0] CAP_LAST = (LINE_AW+1)'(LINES - 1);

  ntt_adapter_state_t state, state_nxt;

  logic [LOG_N-1:0]       in_cnt;
  logic [COEFF_WIDTH-1:0] stage;
  logic                   load_done;
  logic [LINE_AW:0]       cap_cnt;
  logic [LINES-1:0]       seen;
  logic [LOG_N:0]         rd_idx;
  logic                   out_valid;
  logic                   out_last;
  logic [COEFF_WIDTH-1:0] buf_rd;

  logic               in_fire;
  logic               cap_fire;
  logic               addr_oob;
  logic [LINE_AW-1:0] cap_line;
  logic               m_fire;
  logic               rd_en;

  assign s_ready  = (state == ST_LOAD) && !load_done;
  assign in_fire  = s_valid && s_ready;
  assign cap_fire = (state == ST_COMPUTE) && proc_output_active;
  assign addr_oob = 10'(proc_address_out) >= 10'(LINES);
  assign cap_line = proc_address_out[LINE_AW-1:0];
  assign m_fire   = out_valid && m_ready;
  // Refill the output register whenever it is empty or being consumed this cycle.
  assign rd_en    = (state == ST_DRAIN) && !rd_idx[LOG_N] && (!out_valid || m_ready);

  assign m_valid    = out_valid;
  assign m_last     = out_last;
  assign m_data     = out_valid ? buf_rd : '0;
  assign proc_start = (state == ST_START);
  assign busy       = (state != ST_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD:    if (load_done) state_nxt = ST_START;
      ST_START:   state_nxt = ST_COMPUTE;
      ST_COMPUTE: if (cap_fire && (cap_cnt == CAP_LAST)) state_nxt = ST_DRAIN;
      ST_DRAIN:   if (m_fire && out_last) state_nxt = ST_LOAD;
      default:    state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt            <= '0;
      stage             <= '0;
      load_done         <= 1'b0;
      proc_write_enable <= 1'b0;
      proc_address_in   <= '0;
      proc_data_in      <= '0;
      cap_cnt           <= '0;
      seen              <= '0;
      err               <= 1'b0;
      rd_idx            <= '0;
      out_valid         <= 1'b0;
      out_last          <= 1'b0;
      done              <= 1'b0;
    end else begin
      proc_write_enable <= 1'b0;
      if (in_fire) begin
        in_cnt <= in_cnt + LOG_N'(1);
        if (!in_cnt[0]) begin
          stage <= s_data;
        end else begin
          proc_write_enable <= 1'b1;
          proc_address_in   <= in_cnt[LOG_N-1:1];
          proc_data_in      <= {s_data, stage};
        end
        if (&in_cnt) begin
          load_done <= 1'b1;
        end
      end

      if (state == ST_START) begin
        load_done <= 1'b0;
        cap_cnt   <= '0;
        seen      <= '0;
      end

      if (cap_fire) begin
        cap_cnt <= cap_cnt + (LINE_AW+1)'(1);
        if (!addr_oob) begin
          seen[cap_line] <= 1'b1;
        end
      end

      if ((proc_output_active && (state != ST_COMPUTE)) ||
          (cap_fire && (addr_oob || seen[cap_line]))) begin
        err <= 1'b1;
      end

      if (rd_en) begin
        rd_idx    <= rd_idx + (LOG_N+1)'(1);
        out_valid <= 1'b1;
        out_last  <= &rd_idx[LOG_N-1:0];
      end else if (m_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      done <= m_fire && out_last;
      if (m_fire && out_last) begin
        rd_idx <= '0;
      end
    end
  end

  ntt_result_buffer #(
    .LINES           (LINES),
    .LINE_AW         (LINE_AW),
    .COEFFS_PER_LINE (CPL),
    .SEL_AW          (SEL_AW),
    .COEFF_WIDTH     (COEFF_WIDTH)
  ) u_result_buffer (
    .clk     (clk),
    .wr_en   (cap_fire && !addr_oob),
    .wr_line (cap_line),
    .wr_data (proc_out),
    .rd_en   (rd_en),
    .rd_line (rd_idx[LOG_N-1:SEL_AW]),
    .rd_sel  (rd_idx[SEL_AW-1:0]),
    .rd_data (buf_rd)
  );

endmodule

`default_nettype wire

// File: doc/ntt_stream_adapter.md
# ntt_stream_adapter

Streaming front/back end for `ntt_processor`, parametrised in polynomial length, coefficient width and core count. It accepts coefficients one per beat on a valid/ready input stream and packs them two per word into the processor's load port. It then pulses `start` and captures every parallel output line into a local result buffer. Finally it replays the transformed coefficients one per beat on a valid/ready output stream with backpressure and a `last` marker. It sits between the host/DMA interconnect and `ntt_processor`, replacing file-driven loading and unloading.

## Interface
- `LOG_N`, 12: log2 of coefficients per polynomial; default 4096 coefficients = 2048 packed words.
- `COEFF_WIDTH`, 30: bits per coefficient; processor word = 2*COEFF_WIDTH.
- `LOG_CORE_COUNT`, 4: log2 of processor cores C; one output line = C cores × 2 words = 4C coefficients.
- Derived: `LINES` = 2^LOG_N / (4C); `LINE_AW` = LOG_N − 2 − LOG_CORE_COUNT; requires LINE_AW ≥ 1.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `s_valid`  in  1  input coefficient valid.
- `s_ready`  out  1  adapter accepts input.
- `s_data`  in  COEFF_WIDTH  input coefficient, natural order.
- `m_valid`  out  1  output coefficient valid.
- `m_ready`  in  1  downstream accepts.
- `m_data`  out  COEFF_WIDTH  transformed coefficient.
- `m_last`  out  1  final coefficient of the polynomial.
- `proc_write_enable`  out  1  to processor `write_enable`.
- `proc_address_in`  out  LOG_N−1  packed word address.
- `proc_data_in`  out  2*COEFF_WIDTH  {odd coeff, even coeff}.
- `proc_start`  out  1  one-cycle start pulse.
- `proc_output_active`  in  1  processor output line valid.
- `proc_out`  in  4C*COEFF_WIDTH  flattened output; word w = 2i+j (core i, half j) at bits [w*2CW +: 2CW].
- `proc_address_out`  in  9  line index; only bits [LINE_AW−1:0] are used.
- `busy`  out  1  high in START, COMPUTE and DRAIN.
- `done`  out  1  one-cycle pulse after the last output beat is accepted.
- `err`  out  1  sticky protocol error, cleared only by reset.

## Operation
- States: LOAD → START → COMPUTE → DRAIN → LOAD.
- LOAD: `s_ready`=1. The even-index beat is held in a staging register. On the odd-index beat, the next cycle drives `proc_write_enable`=1, `proc_address_in`=k/2 and `proc_data_in`={odd, even}. After word 2^(LOG_N−1)−1 is written, go to START.
- START: `proc_start`=1 for exactly one cycle, then go to COMPUTE.
- COMPUTE: `s_ready`=0. Each cycle with `proc_output_active` writes all 4C coefficients into buffer line `proc_address_out[LINE_AW−1:0]` and increments the capture count. When the count reaches LINES, go to DRAIN.
- DRAIN: stream index n = L*4C + 4i + 2j + h, where h=0 is bits [CW−1:0] and h=1 is bits [2CW−1:CW] of word (i,j) in line L. n runs 0..2^LOG_N−1.
  - `m_last`=1 exactly at n=2^LOG_N−1.
  - After the last handshake: pulse `done`, return to LOAD.
- Coefficients pass through unchanged; the adapter does no modular reduction.
- Error conditions, all of which set `err`:
  - `proc_output_active` outside COMPUTE: data ignored.
  - `proc_address_out` ≥ LINES: line not written, but still counted.
  - A duplicate line address overwrites the earlier line.
- Reset, including mid-operation: state=LOAD, all counters 0, staging cleared, `err`=0.
  - Outputs after reset: `s_ready`=1. `m_valid`, `m_last`, `proc_write_enable`, `proc_start`, `busy` and `done` are 0. Address and data outputs are 0.
  - Buffer contents are not reset.

## Timing
- Input: a beat transfers when `s_valid`&&`s_ready`. Full throughput is one coefficient per cycle.
- Processor write occurs one cycle after the odd beat's handshake.
- `proc_start` asserts the cycle after the final write.
- Capture is same-cycle: `proc_out` is sampled on the edge where `proc_output_active`=1. No stall is possible, so every line must be absorbed.
- `m_valid` rises no later than 2 cycles after entering DRAIN. Full throughput is one beat per cycle while `m_ready`=1.
- While `m_valid`&&!`m_ready`, `m_data` and `m_last` stay stable.
- `m_valid` never drops until the handshake completes.
- `done` rises the cycle after the final handshake; LOAD resumes (`s_ready`=1) on that same cycle.

## Structure
- Package `ntt_pkg`: `COEFF_WIDTH` default, the state enum `ntt_adapter_state_t`, and a function computing LINES/LINE_AW.
- Sub-module `ntt_result_buffer`: LINES × 4C × COEFF_WIDTH storage with a wide line write port and a one-coefficient registered read port, allowing block-RAM inference.

## Test plan
Bench config: LOG_N=4, LOG_CORE_COUNT=1, COEFF_WIDTH=30, giving 16 coefficients and 2 lines. The bench includes a behavioural processor model.
- Load 0..15 with `s_valid` held high → writes to addresses 0..7 with data {1,0},{3,2}…{15,14}. `proc_start` fires exactly once, 1 cycle after the address-7 write.
- Model returns line 1 then line 0, with line L containing 100+8L..107+8L → `m_data` = 100..115 in order, and `m_last` only on 115. `done` pulses once.
- Toggle `m_ready` randomly (~50%) during DRAIN → data stays stable while stalled, no beat is lost or duplicated, sequence matches.
- Assert `proc_output_active` during LOAD, and send `proc_address_out`=5 during COMPUTE → `err`=1 and stays set. The buffer is untouched and the state flow is otherwise unchanged.
- Assert `rst_n` low mid-DRAIN → all outputs are at their reset values immediately (asynchronously). After release, a fresh 16-coefficient run completes correctly.
- Gaps on `s_valid` (every third cycle low) → the write sequence is identical to the back-to-back run.
